// File: rtl/ir_pkg.sv
// Shared types and constants for the IR carrier generator.
package ir_pkg;

  localparam int IR_CARRIER_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } carrier_state_t;

endpackage

// File: rtl/ir_carrier_shadow.sv
// Active/pending carrier configuration: validates loads, raises cfg_err on rejects,
// and swaps pending values in only when the caller signals a period boundary.
module ir_carrier_shadow
  import ir_pkg::*;
#(
  parameter int W            = IR_CARRIER_W,
  parameter int DEFAULT_DIV  = 1316,
  parameter int DEFAULT_HIGH = 439
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_div_in,
  input  logic [W-1:0] i_high_in,
  input  logic         i_apply,
  output logic [W-1:0] o_div,
  output logic [W-1:0] o_div_nxt,
  output logic [W-1:0] o_high_nxt,
  output logic         o_cfg_err
);

  localparam logic [W-1:0] MIN_DIV = W'(2);

  logic [W-1:0] r_div;
  logic [W-1:0] r_high;
  logic [W-1:0] r_pend_div;
  logic [W-1:0] r_pend_high;
  logic         r_pend_v;
  logic         r_cfg_err;
  logic         w_valid;

  assign w_valid = i_load && (i_div_in >= MIN_DIV) && (i_high_in <= i_div_in);

  // A load accepted on the apply edge beats the older pending value.
  always_comb begin
    o_div_nxt  = r_div;
    o_high_nxt = r_high;
    if (i_apply) begin
      if (w_valid) begin
        o_div_nxt  = i_div_in;
        o_high_nxt = i_high_in;
      end else if (r_pend_v) begin
        o_div_nxt  = r_pend_div;
        o_high_nxt = r_pend_high;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div       <= W'(DEFAULT_DIV);
      r_high      <= W'(DEFAULT_HIGH);
      r_pend_div  <= '0;
      r_pend_high <= '0;
      r_pend_v    <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= i_load && !w_valid;
      r_div     <= o_div_nxt;
      r_high    <= o_high_nxt;
      if (i_apply) begin
        r_pend_v <= 1'b0;
      end else if (w_valid) begin
        r_pend_v    <= 1'b1;
        r_pend_div  <= i_div_in;
        r_pend_high <= i_high_in;
      end
    end
  end

  assign o_div     = r_div;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/ir_carrier_gen.sv
// Programmable IR carrier: period/high-time divider with gated start, drain-to-wrap stop
// and glitch-free reconfiguration at period boundaries.
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int W            = IR_CARRIER_W,
  parameter int DEFAULT_DIV  = 1316,
  parameter int DEFAULT_HIGH = 439
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div_in,
  input  logic [W-1:0] high_in,
  output logic         carrier_out,
  output logic         period_tick,
  output logic         busy,
  output logic         cfg_err
);

  carrier_state_t r_state;
  logic [W-1:0]   r_count;
  logic           r_carrier;
  logic           r_tick;

  logic [W-1:0] w_div;
  logic [W-1:0] w_div_nxt;
  logic [W-1:0] w_high_nxt;
  logic [W-1:0] w_count_nxt;
  logic         w_wrap;
  logic         w_apply;
  logic         w_go;

  assign w_wrap      = (r_state != IDLE) && (r_count == w_div - W'(1));
  assign w_apply     = (r_state == IDLE) || w_wrap;
  assign w_count_nxt = w_apply ? '0 : r_count + W'(1);
  // Leave the running states only once the drained period has completed.
  assign w_go        = (r_state == IDLE) ? en : !(!en && (r_state == DRAIN) && w_wrap);

  ir_carrier_shadow #(
    .W           (W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .DEFAULT_HIGH(DEFAULT_HIGH)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .i_load    (load),
    .i_div_in  (div_in),
    .i_high_in (high_in),
    .i_apply   (w_apply),
    .o_div     (w_div),
    .o_div_nxt (w_div_nxt),
    .o_high_nxt(w_high_nxt),
    .o_cfg_err (cfg_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_carrier <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_go) begin
      r_state   <= en ? RUN : DRAIN;
      r_count   <= w_count_nxt;
      r_carrier <= w_count_nxt < w_high_nxt;
      r_tick    <= w_count_nxt == w_div_nxt - W'(1);
    end else begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_carrier <= 1'b0;
      r_tick    <= 1'b0;
    end
  end

  assign carrier_out = r_carrier;
  assign period_tick = r_tick;
  assign busy        = (r_state != IDLE);

endmodule
